b_store_buffer: RTL and testbench

// Posted-write store buffer between the CPU store path and data memory.
// The CPU enqueues stores through a valid/ready handshake. A drain FSM writes

---
 rtl/b_store_buffer.sv | 111 +++++++++++
 tb/tb_b_store_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/b_store_buffer.sv
// Posted-write store buffer: the CPU enqueues stores, a two-state drain FSM
// writes them to memory in order, and loads snoop every occupied entry so the
// youngest matching store is forwarded.
module b_store_buffer #(
  parameter int unsigned width  = 32,
  parameter int unsigned addr_w = 32,
  parameter int unsigned depth  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [addr_w-1:0]       st_addr,
  input  logic [width-1:0]        st_data,
  output logic                    mem_we,
  output logic [addr_w-1:0]       mem_addr,
  output logic [width-1:0]        mem_wdata,
  input  logic                    mem_ack,
  input  logic [addr_w-1:0]       ld_addr,
  output logic                    ld_hit,
  output logic [width-1:0]        ld_data,
  output logic [$clog2(depth):0]  count,
  output logic                    empty
);

  localparam int unsigned PW = $clog2(depth);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic                empty_q;
  logic [addr_w-1:0]   addr_q [depth];
  logic [width-1:0]    data_q [depth];
  logic                push, pop;

  assign st_ready  = (count_q != CW'(depth));
  assign push      = st_valid && st_ready;
  assign count     = count_q;
  assign empty     = empty_q;
  assign mem_addr  = addr_q[rd_ptr_q];
  assign mem_wdata = data_q[rd_ptr_q];
  assign count_d   = count_q + CW'(push) - CW'(pop);

  // Entry storage; payload needs no reset since occupancy comes from count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= st_addr;
      data_q[wr_ptr_q] <= st_data;
    end
  end

  // Pointers, occupancy and FSM state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      state_q  <= IDLE;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      state_q <= state_d;
    end
  end

  // Drain FSM next state and memory request; leaving WRITE is decided from
  // count_q and push directly so the FSM does not depend on count_d.
  always_comb begin
    state_d = state_q;
    mem_we  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        if (mem_ack) begin
          pop = 1'b1;
          if (count_q == CW'(1) && !push) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Load snoop, oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    ld_hit  = 1'b0;
    ld_data = '0;
    for (int unsigned k = 0; k < depth; k++) begin
      idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && (addr_q[idx] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_b_store_buffer.sv
// Directed bench for b_store_buffer.
module tb_b_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic [2:0]  count;
  logic        empty;

  int checks = 0;
  int errors = 0;

  logic [31:0] log_a[$];
  logic [31:0] log_d[$];
  logic [2:0]  maxc = '0;

  b_store_buffer #(.width(32), .addr_w(32), .depth(4)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  // Record completed memory writes and the peak occupancy.
  always @(posedge clk) begin
    if (reset && mem_we && mem_ack) begin
      log_a.push_back(mem_addr);
      log_d.push_back(mem_wdata);
    end
    if (count > maxc) maxc <= count;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int base;
    int n;
    reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
    mem_ack = 1'b0; ld_addr = 32'h10;
    tick(); tick();
    reset = 1'b1;

    // Reset state
    chk("rst_mem_we", mem_we, 0);
    chk("rst_st_ready", st_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_ld_hit", ld_hit, 0);
    chk("rst_ld_data", ld_data, 0);

    // 1. Single store with delayed ack
    st_valid = 1'b1; st_addr = 32'h10; st_data = 32'hDEADBEEF;
    tick();
    st_valid = 1'b0;
    chk("t1_count1", count, 1);
    chk("t1_we_lat", mem_we, 0);
    tick();
    chk("t1_we_c1", mem_we, 1);
    chk("t1_addr_c1", mem_addr, 32'h10);
    chk("t1_data_c1", mem_wdata, 32'hDEADBEEF);
    chk("t1_fwd_head_hit", ld_hit, 1);
    chk("t1_fwd_head_data", ld_data, 32'hDEADBEEF);
    tick();
    chk("t1_we_c2", mem_we, 1);
    chk("t1_addr_c2", mem_addr, 32'h10);
    tick();
    chk("t1_we_c3", mem_we, 1);
    chk("t1_data_c3", mem_wdata, 32'hDEADBEEF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t1_count0", count, 0);
    chk("t1_empty", empty, 1);
    chk("t1_we_off", mem_we, 0);
    chk("t1_log", log_a.size(), 1);

    // 2. Fill, overflow attempt, back-to-back drain
    for (int i = 0; i < 4; i++) begin
      st_valid = 1'b1; st_addr = 32'h100 + 32'(4 * i); st_data = 32'hA0 + 32'(i);
      tick();
    end
    chk("t2_count4", count, 4);
    chk("t2_not_ready", st_ready, 0);
    st_addr = 32'h200; st_data = 32'hFF;
    tick();
    st_valid = 1'b0;
    chk("t2_ignored_count", count, 4);
    ld_addr = 32'h200;
    chk("t2_ignored_hit", ld_hit, 0);
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_we", mem_we, 1);
      chk("t2_addr", mem_addr, 32'h100 + 32'(4 * i));
      chk("t2_data", mem_wdata, 32'hA0 + 32'(i));
      tick();
    end
    mem_ack = 1'b0;
    chk("t2_count0", count, 0);
    chk("t2_we_off", mem_we, 0);

    // 3. Forwarding picks the youngest match
    st_valid = 1'b1; st_addr = 32'h20; st_data = 32'h1;
    tick();
    st_data = 32'h2;
    tick();
    st_valid = 1'b0;
    ld_addr = 32'h20;
    #1;
    chk("t3_hit", ld_hit, 1);
    chk("t3_young", ld_data, 2);
    ld_addr = 32'h24;
    #1;
    chk("t3_miss_hit", ld_hit, 0);
    chk("t3_miss_data", ld_data, 0);
    ld_addr = 32'h20;
    mem_ack = 1'b1;
    tick();
    chk("t3_pop1_count", count, 1);
    chk("t3_pop1_data", ld_data, 2);
    tick();
    mem_ack = 1'b0;
    chk("t3_count0", count, 0);

    // 4. Simultaneous enqueue and pop
    st_valid = 1'b1; st_addr = 32'h40; st_data = 32'h40;
    tick();
    st_addr = 32'h44; st_data = 32'h44;
    tick();
    chk("t4_pre_count", count, 2);
    chk("t4_pre_we", mem_we, 1);
    st_addr = 32'h48; st_data = 32'h48; mem_ack = 1'b1; ld_addr = 32'h48;
    #1;
    chk("t4_no_bypass", ld_hit, 0);
    tick();
    st_valid = 1'b0; mem_ack = 1'b0;
    chk("t4_count", count, 2);
    chk("t4_new_head", mem_addr, 32'h44);
    #1;
    chk("t4_tail_hit", ld_hit, 1);
    chk("t4_tail_data", ld_data, 32'h48);
    ld_addr = 32'h40;
    #1;
    chk("t4_retired", ld_hit, 0);
    mem_ack = 1'b1;
    tick(); tick();
    mem_ack = 1'b0;
    chk("t4_count0", count, 0);

    // 5. Reset in the middle of a write
    base = log_a.size();
    st_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st_addr = 32'h50 + 32'(4 * i); st_data = 32'h500 + 32'(i);
      tick();
    end
    st_valid = 1'b0;
    chk("t5_count3", count, 3);
    chk("t5_we", mem_we, 1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t5_count2", count, 2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    ld_addr = 32'h54;
    #1;
    chk("t5_we_off", mem_we, 0);
    chk("t5_count0", count, 0);
    chk("t5_empty", empty, 1);
    chk("t5_ld_hit", ld_hit, 0);
    chk("t5_ready", st_ready, 1);
    tick();
    chk("t5_abandoned", mem_we, 0);
    chk("t5_acked_n", log_a.size() - base, 1);
    chk("t5_acked_addr", log_a[base], 32'h50);

    // 6. Wrap-around with ack tied high
    base = log_a.size();
    mem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t6_ready", st_ready, 1);
      st_valid = 1'b1; st_addr = 32'(4 * i); st_data = 32'(i);
      tick();
    end
    st_valid = 1'b0;
    n = 0;
    while (!empty && n < 30) begin
      tick();
      n++;
    end
    chk("t6_drained", empty, 1);
    mem_ack = 1'b0;
    chk("t6_n_writes", log_a.size() - base, 10);
    for (int i = 0; i < 10; i++) begin
      if (base + i < log_a.size()) begin
        chk("t6_addr", log_a[base + i], 32'(4 * i));
        chk("t6_data", log_d[base + i], 32'(i));
      end
    end
    chk("t6_max_count", (maxc <= 3'd4), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
